axi_wb: RTL and testbench

- AXI4 write-burst initiator; the write-side counterpart of the AXI read-burst block.
- On a start pulse it issues one INCR burst on the AW channel.
- It pops beats from an arg_0-style FIFO (read side) and drives them onto the W channel, then waits for the B response.
- It sits between a stream-producing kernel's output FIFO and an AXI slave memory port in the HLS-generated datapaths.

---
 rtl/axi_wb_pkg.sv | 28 ++
 rtl/axi_wb_beat_ctr.sv | 41 ++++
 rtl/axi_wb.sv | 163 ++++++++++++++++
 tb/tb_axi_wb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wb_pkg.sv
// Shared definitions for the AXI4 write-burst initiator (axi_wb).
//   - state_e        : FSM state encoding, also exported on the debug port
//   - AXI_BURST_INCR : AWBURST encoding for incrementing bursts
//   - WSTRB_ALL_ONES : wide all-ones strobe word, sliced to DATA_WIDTH/8
//   - axi_size()     : AWSIZE encoding for a given data bus width
package axi_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AW    = 3'd1,
    ST_FETCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_BWAIT = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Wide enough for a 1024-bit data bus; the top slices what it needs.
  localparam int                   WSTRB_MAX      = 128;
  localparam logic [WSTRB_MAX-1:0] WSTRB_ALL_ONES = '1;

  // AWSIZE = log2(bytes per beat).
  function automatic logic [2:0] axi_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_wb_beat_ctr.sv
// Beat counter for one write burst.
//   clk, rst : clock, synchronous active-low reset
//   clear    : zero the count (new burst accepted)
//   inc      : advance by one beat (non-final beat handshaked)
//   len      : AXI-encoded burst length (beats = len+1)
//   last     : the beat currently being sent is the final one
// The compare against len is made before any increment, so len = all-ones
// gives 2^LEN_WIDTH beats without the counter ever wrapping.
module axi_wb_beat_ctr #(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 inc,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 last
);

  logic [LEN_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == len);

endmodule

// File: rtl/axi_wb.sv
// AXI4 write-burst initiator. On an accepted start it issues one INCR burst
// on AW, then alternates FETCH (pop one FIFO word into the beat register)
// and SEND (present it on W) for burst_len+1 beats, then waits for B.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   start, base_addr,
//   burst_len                : request; operands latched when start accepted
//   valid                    : burst complete (DONE), held until next start
//   arg_0_out_data,
//   arg_0_read_ready         : FIFO head word / FIFO non-empty
//   arg_0_read_valid         : pop request
//   arg_3_s_axi_aw*          : AXI write address channel
//   arg_3_s_axi_w*           : AXI write data channel (no wlast)
//   arg_3_s_axi_bvalid/bready: AXI write response (response code ignored)
//   dbg_state                : current FSM state
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid && ready are both high. Our valid/ready outputs are pure
// decodes of state_q, never of inputs; once raised, valid stays high with
// stable payload until the transfer happens. A ready seen from the other
// side before our valid rises is legal and completes on the first cycle
// our valid is high.
module axi_wb
  import axi_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [LEN_WIDTH-1:0]    burst_len,
  output logic                    valid,
  input  logic [DATA_WIDTH-1:0]   arg_0_out_data,
  input  logic                    arg_0_read_ready,
  output logic                    arg_0_read_valid,
  output logic [ADDR_WIDTH-1:0]   arg_3_s_axi_awaddr,
  output logic [1:0]              arg_3_s_axi_awburst,
  output logic [LEN_WIDTH-1:0]    arg_3_s_axi_awlen,
  output logic [2:0]              arg_3_s_axi_awsize,
  output logic                    arg_3_s_axi_awvalid,
  input  logic                    arg_3_s_axi_awready,
  output logic [DATA_WIDTH-1:0]   arg_3_s_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] arg_3_s_axi_wstrb,
  output logic                    arg_3_s_axi_wvalid,
  input  logic                    arg_3_s_axi_wready,
  input  logic                    arg_3_s_axi_bvalid,
  output logic                    arg_3_s_axi_bready,
  output state_e                  dbg_state
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    ctr_clear, ctr_inc, ctr_last;

  axi_wb_beat_ctr #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_beat_ctr (
    .clk  (clk),
    .rst  (rst),
    .clear(ctr_clear),
    .inc  (ctr_inc),
    .len  (len_q),
    .last (ctr_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    addr_d              = addr_q;
    len_d               = len_q;
    wdata_d             = wdata_q;
    ctr_clear           = 1'b0;
    ctr_inc             = 1'b0;
    valid               = 1'b0;
    arg_0_read_valid    = 1'b0;
    arg_3_s_axi_awvalid = 1'b0;
    arg_3_s_axi_wvalid  = 1'b0;
    arg_3_s_axi_bready  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          len_d     = burst_len;
          ctr_clear = 1'b1;
          state_d   = ST_AW;
        end
      end
      ST_AW: begin
        arg_3_s_axi_awvalid = 1'b1;
        if (arg_3_s_axi_awready) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        arg_0_read_valid = 1'b1;
        if (arg_0_read_ready) begin
          wdata_d = arg_0_out_data;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        arg_3_s_axi_wvalid = 1'b1;
        if (arg_3_s_axi_wready) begin
          if (ctr_last) begin
            state_d = ST_BWAIT;
          end else begin
            ctr_inc = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_BWAIT: begin
        arg_3_s_axi_bready = 1'b1;
        if (arg_3_s_axi_bvalid) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        valid = 1'b1;
        // Back-to-back bursts skip IDLE.
        if (start) begin
          addr_d    = base_addr;
          len_d     = burst_len;
          ctr_clear = 1'b1;
          state_d   = ST_AW;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign arg_3_s_axi_awaddr  = addr_q;
  assign arg_3_s_axi_awlen   = len_q;
  assign arg_3_s_axi_awburst = AXI_BURST_INCR;
  assign arg_3_s_axi_awsize  = axi_size(DATA_WIDTH);
  assign arg_3_s_axi_wdata   = wdata_q;
  assign arg_3_s_axi_wstrb   = WSTRB_ALL_ONES[STRB_WIDTH-1:0];
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_axi_wb.sv
// Directed testbench for axi_wb. A bench-side FIFO queue feeds the read
// port, the AXI slave is modelled by ready/response knobs, and every W beat
// is checked against an expected queue loaded with the same words.
module tb_axi_wb;
  import axi_wb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        start;
  logic [15:0] base_addr;
  logic [7:0]  burst_len;
  logic        valid;
  logic [31:0] arg_0_out_data;
  logic        arg_0_read_ready;
  logic        arg_0_read_valid;
  logic [15:0] awaddr;
  logic [1:0]  awburst;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic        bvalid, bready;
  state_e      dbg_state;

  axi_wb dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .base_addr           (base_addr),
    .burst_len           (burst_len),
    .valid               (valid),
    .arg_0_out_data      (arg_0_out_data),
    .arg_0_read_ready    (arg_0_read_ready),
    .arg_0_read_valid    (arg_0_read_valid),
    .arg_3_s_axi_awaddr  (awaddr),
    .arg_3_s_axi_awburst (awburst),
    .arg_3_s_axi_awlen   (awlen),
    .arg_3_s_axi_awsize  (awsize),
    .arg_3_s_axi_awvalid (awvalid),
    .arg_3_s_axi_awready (awready),
    .arg_3_s_axi_wdata   (wdata),
    .arg_3_s_axi_wstrb   (wstrb),
    .arg_3_s_axi_wvalid  (wvalid),
    .arg_3_s_axi_wready  (wready),
    .arg_3_s_axi_bvalid  (bvalid),
    .arg_3_s_axi_bready  (bready),
    .dbg_state           (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int pops, whs, aws, bhs, burst_beats;
  logic [15:0] aw_addr_seen;
  logic [7:0]  aw_len_seen;
  int fifo_hold, w_hold, b_wait, b_delay;
  int trig_fifo_beat = -1;
  int trig_w_beat    = -1;
  int stall_rv, stall_w;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    arg_0_read_ready = (fifo_q.size() > 0) && (fifo_hold == 0);
    arg_0_out_data   = (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    awready          = 1'b1;
    wready           = (w_hold == 0);
    bvalid           = (b_wait >= b_delay);
  endtask

  // One clock: note the handshakes that will complete at the coming edge,
  // advance, then account for them and update the slave/FIFO model.
  task automatic tick();
    bit pop_hs, w_hs, aw_hs, b_hs;
    logic [31:0] wd;
    pop_hs = arg_0_read_valid && arg_0_read_ready;
    w_hs   = wvalid && wready;
    aw_hs  = awvalid && awready;
    b_hs   = bready && bvalid;
    wd     = wdata;
    if (arg_0_read_valid && !arg_0_read_ready && fifo_hold > 0) stall_rv++;
    if (wvalid && !wready) begin
      stall_w++;
      if (exp_q.size() > 0) chk("wdata_stall", wdata, exp_q[0]);
    end
    if (bready) b_wait++;
    if (aw_hs) begin
      aw_addr_seen = awaddr;
      aw_len_seen  = awlen;
    end
    @(posedge clk);
    #1;
    if (pop_hs && fifo_q.size() > 0) begin
      pops++;
      void'(fifo_q.pop_front());
    end
    if (aw_hs) aws++;
    if (w_hs) begin
      whs++;
      if (exp_q.size() == 0) chk("wbeat_extra", 64'd1, 64'd0);
      else chk("wbeat", wd, exp_q.pop_front());
      if (whs == burst_beats) chk("state_after_last", dbg_state, ST_BWAIT);
    end
    if (b_hs) begin
      bhs++;
      b_wait = 0;
    end
    if (fifo_hold > 0) fifo_hold--;
    if (w_hold > 0) w_hold--;
    if (w_hs && whs == trig_fifo_beat) fifo_hold = 5;
    if (w_hs && whs == trig_w_beat) w_hold = 4;
    drive_inputs();
  endtask

  task automatic load_burst(input logic [7:0] len, input logic [31:0] seed, input int b_del);
    fifo_q.delete();
    exp_q.delete();
    for (int i = 0; i <= int'(len); i++) begin
      fifo_q.push_back(seed + 32'(i));
      exp_q.push_back(seed + 32'(i));
    end
    pops = 0; whs = 0; aws = 0; bhs = 0;
    burst_beats = int'(len) + 1;
    b_delay = b_del; b_wait = 0;
    fifo_hold = 0; w_hold = 0;
    stall_rv = 0; stall_w = 0;
    drive_inputs();
  endtask

  task automatic run_burst(input logic [15:0] addr, input logic [7:0] len,
                           input logic [31:0] seed, input int exp_lat,
                           input int b_del, input bit start_in_send);
    int  n;
    bit  done, spurious;
    load_burst(len, seed, b_del);
    base_addr = addr;
    burst_len = len;
    start     = 1'b1;
    n = 0; done = 0; spurious = 0;
    while (!done && n < 2000) begin
      if (start_in_send && wvalid && !spurious) begin
        start     = 1'b1;
        base_addr = 16'h2222;
        burst_len = 8'd7;
        spurious  = 1;
      end
      tick();
      n++;
      start = 1'b0;
      if (n == 1) chk("valid_drop", valid, 1'b0);
      if (valid) done = 1;
    end
    chk("burst_done", done, 1'b1);
    chk("aw_count", aws, 1);
    chk("awaddr", aw_addr_seen, addr);
    chk("awlen", aw_len_seen, len);
    chk("w_count", whs, int'(len) + 1);
    chk("pop_count", pops, int'(len) + 1);
    chk("b_count", bhs, 1);
    chk("fifo_left", fifo_q.size(), 0);
    if (exp_lat > 0) chk("latency", n, exp_lat);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    start = 0; base_addr = 0; burst_len = 0;
    b_delay = 0; b_wait = 0; fifo_hold = 0; w_hold = 0;

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      start            = 1'($urandom_range(0, 1));
      base_addr        = 16'($urandom_range(0, 16'hFFFF));
      burst_len        = 8'($urandom_range(0, 255));
      arg_0_out_data   = $urandom;
      arg_0_read_ready = 1'($urandom_range(0, 1));
      awready          = 1'($urandom_range(0, 1));
      wready           = 1'($urandom_range(0, 1));
      bvalid           = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_valid", valid, 1'b0);
    chk("rst_read_valid", arg_0_read_valid, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_awaddr", awaddr, 16'h0);
    chk("rst_awlen", awlen, 8'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_awburst", awburst, 2'b01);
    chk("rst_awsize", awsize, 3'b010);
    chk("rst_wstrb", wstrb, 4'hF);
    start = 0;
    load_burst(8'd0, 32'h0, 0);
    fifo_q.delete(); exp_q.delete();
    drive_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic burst, all readies high: 1 + 2*4 + 1 + 1 = 11 cycles.
    run_burst(16'h0040, 8'd3, 32'h0000_00A0, 11, 0, 0);

    // FIFO empty 5 cycles before beat 2, wready low 3 cycles on beat 1.
    trig_w_beat    = 1;
    trig_fifo_beat = 2;
    run_burst(16'h0040, 8'd3, 32'h0000_00A0, 19, 0, 0);
    chk("stall_read_valid", stall_rv, 5);
    chk("stall_wready", stall_w, 3);
    trig_w_beat    = -1;
    trig_fifo_beat = -1;

    // 256-beat burst: 1 + 2*256 + 1 + 1 = 515 cycles.
    run_burst(16'h0100, 8'd255, 32'h1000_0000, 515, 0, 0);

    // Delayed B response, start pulsed during SEND must be ignored.
    run_burst(16'h0200, 8'd3, 32'h0000_00B0, 21, 10, 1);
    chk("done_after_b", dbg_state, ST_DONE);
    // Start from DONE: new burst straight to AW.
    run_burst(16'h1000, 8'd3, 32'h0000_00C0, 11, 0, 0);

    // Reset while sending beat 2.
    load_burst(8'd3, 32'h0000_00D0, 0);
    base_addr = 16'h0300;
    burst_len = 8'd3;
    start     = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (whs == 2 && wvalid) break;
      tick();
      start = 1'b0;
    end
    chk("mid_in_send", wvalid, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_state", dbg_state, ST_IDLE);
    chk("mid_rst_wvalid", wvalid, 1'b0);
    chk("mid_rst_read_valid", arg_0_read_valid, 1'b0);
    chk("mid_rst_awvalid", awvalid, 1'b0);
    chk("mid_rst_bready", bready, 1'b0);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_wdata", wdata, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_burst(16'h0400, 8'd3, 32'h0000_00E0, 11, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
